// File: rtl/idct_n_1d_seq.sv
// Sequential N-point 1-D inverse DCT with HEVC integer coefficients.
// One multiply-accumulate per cycle. Each sample is rounded, shifted and saturated to 16 bits.
module idct_n_1d_seq #(
  parameter int N     = 4,
  parameter int SHIFT = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic signed [15:0] x [N],
  output logic signed [15:0] y [N],
  output logic               busy,
  output logic               done
);

  localparam int M    = $clog2(N);
  localparam int STEP = 32 / N;
  localparam logic [M-1:0]       LAST = M'(N - 1);
  localparam logic signed [31:0] RND  = 32'sd1 <<< (SHIFT - 1);

  if (N != 4 && N != 8 && N != 16 && N != 32) begin : g_bad_n
    $error("idct_n_1d_seq: N must be 4, 8, 16 or 32");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, STORE, NEXT, DONE} state_t;

  state_t              state, state_nxt;
  logic signed [15:0]  xr [N];
  logic signed [31:0]  acc;
  logic [M-1:0]        n_idx, k_idx;
  logic signed [7:0]   coef_cur;
  logic signed [23:0]  prod;
  logic signed [31:0]  rnd_sum;
  logic signed [15:0]  sat;

  // Magnitude of the 32-point DCT basis at angle m*pi/64, m = 0..32.
  function automatic logic signed [7:0] cos_tab(input int m);
    case (m)
      0:  return 8'sd64;  1:  return 8'sd90;  2:  return 8'sd90;  3:  return 8'sd90;
      4:  return 8'sd89;  5:  return 8'sd88;  6:  return 8'sd87;  7:  return 8'sd85;
      8:  return 8'sd83;  9:  return 8'sd82;  10: return 8'sd80;  11: return 8'sd78;
      12: return 8'sd75;  13: return 8'sd73;  14: return 8'sd70;  15: return 8'sd67;
      16: return 8'sd64;  17: return 8'sd61;  18: return 8'sd57;  19: return 8'sd54;
      20: return 8'sd50;  21: return 8'sd46;  22: return 8'sd43;  23: return 8'sd38;
      24: return 8'sd36;  25: return 8'sd31;  26: return 8'sd25;  27: return 8'sd22;
      28: return 8'sd18;  29: return 8'sd13;  30: return 8'sd9;   31: return 8'sd4;
      default: return 8'sd0;
    endcase
  endfunction

  // C[k][n] of the N-point matrix equals row k*32/N of the 32-point matrix.
  function automatic logic signed [7:0] coef(input int k, input int n);
    int a;
    a = (k * STEP * (2 * n + 1)) % 128;
    if (a > 64) a = 128 - a;
    if (k == 0)      return 8'sd64;
    else if (a > 32) return -cos_tab(64 - a);
    else             return cos_tab(a);
  endfunction

  assign coef_cur = coef(int'(k_idx), int'(n_idx));
  assign prod     = xr[k_idx] * coef_cur;
  assign rnd_sum  = (acc + RND) >>> SHIFT;

  always_comb begin
    if (rnd_sum > 32'sd32767)       sat = 16'sh7fff;
    else if (rnd_sum < -32'sd32768) sat = 16'sh8000;
    else                            sat = rnd_sum[15:0];
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = MAC;
      MAC:     if (k_idx == LAST) state_nxt = STORE;
      STORE:   state_nxt = NEXT;
      NEXT:    state_nxt = (n_idx == LAST) ? DONE : CLEAR;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // NOTE: y and xr are register banks, not RAM. They are reset explicitly so that no
  // partial result survives a mid-run reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        xr[i] <= '0;
        y[i]  <= '0;
      end
      acc   <= '0;
      n_idx <= '0;
      k_idx <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          xr    <= x;
          n_idx <= '0;
        end
        CLEAR: begin
          acc   <= '0;
          k_idx <= '0;
        end
        MAC: begin
          acc <= acc + {{8{prod[23]}}, prod};
          if (k_idx != LAST) k_idx <= k_idx + M'(1);
        end
        STORE: y[n_idx] <= sat;
        NEXT: begin
          if (n_idx == LAST) done  <= 1'b1;
          else               n_idx <= n_idx + M'(1);
        end
        DONE: if (!start) done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
